if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 16-bit pipelined CPU.
- Holds the PC register and supplies `pc_next` (PC+1) to the PC-select mux. Each cycle it consumes the mux's chosen PC as the next fetch address.
- Issues requests on the shared instruction-memory port with a req/ready handshake and fills the IF/ID pipeline register.
- Supports hazard-unit stall, branch/jump flush, and yielding the memory bus to data accesses.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, bubble instruction written into IF/ID.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pc_in  in  16  next PC chosen by the PC-select mux
- pc_next  out  16  combinational PC+1, fed to the PC-select mux
- stall  in  1  hazard unit: freeze PC and IF/ID
- flush  in  1  taken branch/jump/interrupt: kill the instruction being fetched
- mem_busy  in  1  data stage owns the shared memory bus this cycle
- imem_req  out  1  fetch request
- imem_addr  out  16  fetch address (= pc)
- imem_ready  in  1  memory returns data this cycle; may assert in the same cycle as req
- imem_rdata  in  16  fetched instruction, valid when imem_ready=1
- pc  out  16  current PC register
- if_instr  out  16  IF/ID instruction
- if_pc_next  out  16  IF/ID copy of PC+1 for the fetched instruction
- if_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, rst=1), effective immediately:
  - pc=RESET_PC, if_instr=NOP_INSTR, if_pc_next=0, if_valid=0.
  - FSM=FETCH, kill=0, hold buffer cleared.
  - imem_req=0 while rst is high.
- pc_next = pc+1, 16-bit wrap: 16'hFFFF -> 16'h0000.
- imem_addr = pc at all times.
- FSM states: FETCH, WAIT, HOLD.
- FETCH:
  - imem_req = !mem_busy.
  - mem_busy=1: no request. If !stall, IF/ID <= bubble (NOP, valid=0). PC unchanged.
  - req and ready, !stall, !flush: IF/ID <= {imem_rdata, pc_next, 1}; pc <= pc_in; stay FETCH. Throughput is 1 instr/cycle.
  - req and ready, stall=1: hold buffer <= imem_rdata; -> HOLD; PC and IF/ID unchanged.
  - req and !ready: -> WAIT.
- WAIT:
  - imem_req held at 1; the request is never withdrawn before ready.
  - Ready rules are the same as in FETCH, except when kill=1: the returned data is discarded, IF/ID <= bubble, kill <= 0, -> FETCH.
- HOLD:
  - imem_req=0.
  - When stall=0: IF/ID <= {buffer, pc_next, 1}; pc <= pc_in; -> FETCH.
- Flush (priority over stall and over normal progress):
  - IF/ID <= bubble; pc <= pc_in (redirect target).
  - If a request is outstanding (WAIT, or FETCH with req and !ready): kill <= 1 and stay in/enter WAIT. The redirected fetch starts after the stale ready.
  - Otherwise (FETCH, HOLD, or same-cycle ready): -> FETCH, and any held or returned data is dropped.
- Priority: rst > flush > stall > mem_busy > normal.
- PC update rule: pc is written only on an accepted fetch or on flush. Stall freezes the PC, even while the memory is waiting.
- Reset mid-WAIT: the handshake is abandoned, and memory must tolerate req dropping.
- Stall in WAIT followed by ready: data is buffered and the FSM goes to HOLD.

Decomposition:
- Shared CPU package: NOP_INSTR constant, RESET_PC, and the FSM state encoding (FETCH=2'd0, WAIT=2'd1, HOLD=2'd2).
- One natural sub-module, if_id_reg: the IF/ID register with load/bubble/hold controls and async reset. The FSM and PC register stay in if_stage.

Test Plan:
- Reset then free run, imem_ready tied 1, pc_in=pc_next: pc steps 0,1,2,3. if_instr equals the memory words at 0,1,2, one cycle later, with if_valid=1 and if_pc_next=1,2,3.
- Ready delayed 2 cycles at pc=4: imem_req stays 1 for 3 cycles; then if_instr=mem[4], pc=5. No duplicate or lost fetch.
- stall high 3 cycles with ready=1 at pc=7: pc stays 7 and IF/ID is unchanged. The word is buffered, and 1 cycle after stall drops if_instr=mem[7], pc=8.
- flush with pc_in=16'h0040 during WAIT at pc=9: IF/ID is a bubble (0x0800, valid=0). The stale ready is discarded. The next accepted instruction is mem[0x40], with if_pc_next=0x41.
- mem_busy=1 for 1 cycle at pc=12: imem_req=0 and one bubble is inserted; then mem[12] is fetched normally.
- pc=16'hFFFF: pc_next=16'h0000, and the fetch wraps to address 0. Async rst asserted mid-WAIT clears all outputs within the same cycle.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared CPU definitions used by the instruction-fetch stage: reset PC,
// bubble encoding and the fetch FSM state type.
package if_stage_pkg;

  localparam logic [15:0] CPU_RESET_PC  = 16'h0000;
  localparam logic [15:0] CPU_NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } if_state_e;

  function automatic logic [15:0] inc_pc(input logic [15:0] p);
    return p + 16'd1;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: bubble overrides load, otherwise contents hold.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = CPU_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_next_in,
  output logic [15:0] instr,
  output logic [15:0] pc_next,
  output logic        valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr   <= NOP_INSTR;
      pc_next <= '0;
      valid   <= 1'b0;
    end else if (bubble) begin
      instr   <= NOP_INSTR;
      pc_next <= '0;
      valid   <= 1'b0;
    end else if (load) begin
      instr   <= instr_in;
      pc_next <= pc_next_in;
      valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem req/ready handshake with
// stall/flush/bus-yield handling, and the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = CPU_RESET_PC,
  parameter logic [15:0] NOP_INSTR = CPU_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_in,
  output logic [15:0] pc_next,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_busy,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] pc,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc_next,
  output logic        if_valid
);

  if_state_e   state, state_n;
  logic        kill, kill_n;
  logic [15:0] hold_buf, buf_n;
  logic [15:0] pc_n;
  logic        fetch_req;
  logic        ld, bub;
  logic [15:0] ld_instr;

  assign pc_next   = inc_pc(pc);
  assign imem_addr = pc;
  assign fetch_req = (state == WAIT) || ((state == FETCH) && !mem_busy);
  assign imem_req  = fetch_req && !rst;
  assign ld_instr  = (state == HOLD) ? hold_buf : imem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      kill     <= 1'b0;
      hold_buf <= '0;
      pc       <= RESET_PC;
    end else begin
      state    <= state_n;
      kill     <= kill_n;
      hold_buf <= buf_n;
      pc       <= pc_n;
    end
  end

  // Whenever the stage is not stalled and delivers nothing, IF/ID takes a
  // bubble so the decode stage never sees the same instruction twice.
  always_comb begin
    state_n = state;
    kill_n  = kill;
    buf_n   = hold_buf;
    pc_n    = pc;
    ld      = 1'b0;
    bub     = 1'b0;
    case (state)
      FETCH: begin
        if (flush) begin
          bub  = 1'b1;
          pc_n = pc_in;
          if (fetch_req && !imem_ready) begin
            kill_n  = 1'b1;
            state_n = WAIT;
          end
        end else if (stall) begin
          if (fetch_req) begin
            if (imem_ready) begin
              buf_n   = imem_rdata;
              state_n = HOLD;
            end else begin
              state_n = WAIT;
            end
          end
        end else if (mem_busy) begin
          bub = 1'b1;
        end else if (imem_ready) begin
          ld   = 1'b1;
          pc_n = pc_in;
        end else begin
          bub     = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          bub  = 1'b1;
          pc_n = pc_in;
          if (imem_ready) begin
            kill_n  = 1'b0;
            state_n = FETCH;
          end else begin
            kill_n = 1'b1;
          end
        end else if (kill) begin
          // Stale response from before a redirect: swallow it.
          if (imem_ready) begin
            bub     = 1'b1;
            kill_n  = 1'b0;
            state_n = FETCH;
          end else if (!stall) begin
            bub = 1'b1;
          end
        end else if (imem_ready) begin
          if (stall) begin
            buf_n   = imem_rdata;
            state_n = HOLD;
          end else begin
            ld      = 1'b1;
            pc_n    = pc_in;
            state_n = FETCH;
          end
        end else if (!stall) begin
          bub = 1'b1;
        end
      end
      HOLD: begin
        if (flush) begin
          bub     = 1'b1;
          pc_n    = pc_in;
          state_n = FETCH;
        end else if (!stall) begin
          ld      = 1'b1;
          pc_n    = pc_in;
          state_n = FETCH;
        end
      end
      default: begin
        state_n = FETCH;
        kill_n  = 1'b0;
      end
    endcase
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .load      (ld),
    .bubble    (bub),
    .instr_in  (ld_instr),
    .pc_next_in(pc_next),
    .instr     (if_instr),
    .pc_next   (if_pc_next),
    .valid     (if_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: transaction-level fetch model compared every
// cycle, plus literal expectations at scenario milestones.
module tb_if_stage;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc_in;
  logic [15:0] pc_next;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        mem_busy = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [15:0] imem_rdata;
  logic [15:0] pc;
  logic [15:0] if_instr;
  logic [15:0] if_pc_next;
  logic        if_valid;

  logic        redir = 1'b0;
  logic [15:0] redir_tgt = '0;
  logic        chk_en = 1'b0;
  int          n_err = 0;
  int          n_checks = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], ~a[7:0]};
  endfunction

  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 16'hDEAD;
  assign pc_in      = redir ? redir_tgt : pc_next;

  if_stage #(
    .RESET_PC (16'h0000),
    .NOP_INSTR(16'h0800)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .pc_next   (pc_next),
    .stall     (stall),
    .flush     (flush),
    .mem_busy  (mem_busy),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .pc        (pc),
    .if_instr  (if_instr),
    .if_pc_next(if_pc_next),
    .if_valid  (if_valid)
  );

  task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: tracks an outstanding request, whether it is stale after a
  // redirect, and a word parked while the pipeline is stalled.
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pcn;
    logic        valid;
    logic        outst;
    logic        stale;
    logic        have;
    logic [15:0] word;
  } mstate_t;

  mstate_t     m, nx;
  logic        e_req, got;
  logic [15:0] tgt;

  always_comb begin
    nx    = m;
    e_req = !m.have && (m.outst || !mem_busy);
    got   = e_req && imem_ready;
    tgt   = redir ? redir_tgt : m.pc + 16'd1;
    if (flush) begin
      nx.instr = NOP; nx.pcn = '0; nx.valid = 1'b0;
      nx.pc    = tgt;
      nx.stale = e_req && !imem_ready;
      nx.outst = e_req && !imem_ready;
      nx.have  = 1'b0;
    end else if (got && m.stale) begin
      nx.instr = NOP; nx.pcn = '0; nx.valid = 1'b0;
      nx.stale = 1'b0;
      nx.outst = 1'b0;
    end else if (got && stall) begin
      nx.have  = 1'b1;
      nx.word  = mem_word(m.pc);
      nx.outst = 1'b0;
    end else if (got) begin
      nx.instr = mem_word(m.pc); nx.pcn = m.pc + 16'd1; nx.valid = 1'b1;
      nx.pc    = tgt;
      nx.outst = 1'b0;
    end else if (m.have && !stall) begin
      nx.instr = m.word; nx.pcn = m.pc + 16'd1; nx.valid = 1'b1;
      nx.pc    = tgt;
      nx.have  = 1'b0;
    end else begin
      nx.outst = e_req;
      if (!stall) begin
        nx.instr = NOP; nx.pcn = '0; nx.valid = 1'b0;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{pc: 16'h0000, instr: NOP, pcn: 16'h0000, valid: 1'b0,
                    outst: 1'b0, stale: 1'b0, have: 1'b0, word: 16'h0000};
    else     m <= nx;
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check1 ("imem_req",   imem_req,   e_req);
      check16("pc",         pc,         m.pc);
      check16("imem_addr",  imem_addr,  m.pc);
      check16("pc_next",    pc_next,    m.pc + 16'd1);
      check16("if_instr",   if_instr,   m.instr);
      check16("if_pc_next", if_pc_next, m.pcn);
      check1 ("if_valid",   if_valid,   m.valid);
    end
  end

  task automatic cyc(input logic st, input logic fl, input logic bz, input logic rd,
                     input logic rdr = 1'b0, input logic [15:0] t = 16'h0000);
    stall = st; flush = fl; mem_busy = bz; imem_ready = rd;
    redir = rdr; redir_tgt = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check16("reset_pc",    pc,       16'h0000);
    check16("reset_instr", if_instr, 16'h0800);
    check1 ("reset_valid", if_valid, 1'b0);
    check1 ("reset_req",   imem_req, 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Free run
    repeat (3) cyc(0, 0, 0, 1);
    check16("run_pc",    pc,         16'h0003);
    check16("run_instr", if_instr,   16'h02FD);
    check16("run_pcn",   if_pc_next, 16'h0003);
    check1 ("run_valid", if_valid,   1'b1);
    cyc(0, 0, 0, 1);

    // Ready delayed two cycles at pc=4
    cyc(0, 0, 0, 0);
    check1("wait_req1", imem_req, 1'b1);
    cyc(0, 0, 0, 0);
    check1("wait_req2", imem_req, 1'b1);
    cyc(0, 0, 0, 1);
    check16("wait_instr", if_instr, 16'h04FB);
    check16("wait_pc",    pc,       16'h0005);
    repeat (2) cyc(0, 0, 0, 1);

    // Stall three cycles with ready at pc=7
    repeat (3) cyc(1, 0, 0, 1);
    check16("stall_pc",    pc,       16'h0007);
    check16("stall_instr", if_instr, 16'h06F9);
    check1 ("hold_req",    imem_req, 1'b0);
    cyc(0, 0, 0, 1);
    check16("hold_instr", if_instr, 16'h07F8);
    check16("hold_pc",    pc,       16'h0008);
    cyc(0, 0, 0, 1);

    // Flush during WAIT at pc=9
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1'b1, 16'h0040);
    check16("flush_instr", if_instr, 16'h0800);
    check1 ("flush_valid", if_valid, 1'b0);
    check16("flush_pc",    pc,       16'h0040);
    cyc(0, 0, 0, 1);
    check1 ("stale_valid", if_valid, 1'b0);
    check16("stale_pc",    pc,       16'h0040);
    cyc(0, 0, 0, 1);
    check16("redir_instr", if_instr,   16'h40BF);
    check16("redir_pcn",   if_pc_next, 16'h0041);

    // Flush with same-cycle ready, redirect to 12
    cyc(0, 1, 0, 1, 1'b1, 16'h000C);
    check16("flush2_pc", pc, 16'h000C);

    // mem_busy for one cycle at pc=12
    stall = 1'b0; flush = 1'b0; mem_busy = 1'b1; imem_ready = 1'b1; redir = 1'b0;
    #1;
    check1("busy_req", imem_req, 1'b0);
    cyc(0, 0, 1, 1);
    check1 ("busy_valid", if_valid, 1'b0);
    check16("busy_pc",    pc,       16'h000C);
    cyc(0, 0, 0, 1);
    check16("busy_instr", if_instr, 16'h0CF3);

    // Wrap from 16'hFFFF
    cyc(0, 1, 0, 1, 1'b1, 16'hFFFF);
    check16("wrap_pc_next", pc_next, 16'h0000);
    cyc(0, 0, 0, 1);
    check16("wrap_instr", if_instr,   16'hFF00);
    check16("wrap_pcn",   if_pc_next, 16'h0000);
    check16("wrap_pc",    pc,         16'h0000);

    // Stall arriving during WAIT, then ready: word parked until stall drops
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    check16("swait_pc", pc, 16'h0000);
    cyc(0, 0, 0, 1);
    check16("swait_instr", if_instr, 16'h00FF);
    check16("swait_pc2",   pc,       16'h0001);

    // Asynchronous reset in the middle of a WAIT
    cyc(0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check1 ("arst_req",   imem_req,   1'b0);
    check16("arst_pc",    pc,         16'h0000);
    check16("arst_instr", if_instr,   16'h0800);
    check16("arst_pcn",   if_pc_next, 16'h0000);
    check1 ("arst_valid", if_valid,   1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) cyc(0, 0, 0, 1);
    check16("post_pc",    pc,       16'h0002);
    check16("post_instr", if_instr, 16'h01FE);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
